alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 144 ++++++++++++++
 tb/tb_alu_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage RV32I integer execution unit that broadcasts results
//            on the reservation-station result bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ILEN
`define ILEN 6
`endif
`ifndef RLEN
`define RLEN 32
`endif
`ifndef RBID
`define RBID 4
`endif

package alu_pipe_pkg;
  localparam logic [`ILEN-1:0] c_ADD   = `ILEN'd1;
  localparam logic [`ILEN-1:0] c_ADDI  = `ILEN'd2;
  localparam logic [`ILEN-1:0] c_SUB   = `ILEN'd3;
  localparam logic [`ILEN-1:0] c_AND   = `ILEN'd4;
  localparam logic [`ILEN-1:0] c_ANDI  = `ILEN'd5;
  localparam logic [`ILEN-1:0] c_OR    = `ILEN'd6;
  localparam logic [`ILEN-1:0] c_ORI   = `ILEN'd7;
  localparam logic [`ILEN-1:0] c_XOR   = `ILEN'd8;
  localparam logic [`ILEN-1:0] c_XORI  = `ILEN'd9;
  localparam logic [`ILEN-1:0] c_SLL   = `ILEN'd10;
  localparam logic [`ILEN-1:0] c_SLLI  = `ILEN'd11;
  localparam logic [`ILEN-1:0] c_SRL   = `ILEN'd12;
  localparam logic [`ILEN-1:0] c_SRLI  = `ILEN'd13;
  localparam logic [`ILEN-1:0] c_SRA   = `ILEN'd14;
  localparam logic [`ILEN-1:0] c_SRAI  = `ILEN'd15;
  localparam logic [`ILEN-1:0] c_SLT   = `ILEN'd16;
  localparam logic [`ILEN-1:0] c_SLTI  = `ILEN'd17;
  localparam logic [`ILEN-1:0] c_SLTU  = `ILEN'd18;
  localparam logic [`ILEN-1:0] c_SLTIU = `ILEN'd19;
  localparam logic [`ILEN-1:0] c_BEQ   = `ILEN'd20;
  localparam logic [`ILEN-1:0] c_BNE   = `ILEN'd21;
  localparam logic [`ILEN-1:0] c_BLT   = `ILEN'd22;
  localparam logic [`ILEN-1:0] c_BGE   = `ILEN'd23;
  localparam logic [`ILEN-1:0] c_BLTU  = `ILEN'd24;
  localparam logic [`ILEN-1:0] c_BGEU  = `ILEN'd25;
  localparam logic [`ILEN-1:0] c_JALR  = `ILEN'd26;
endpackage

module alu_pipe
  import alu_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jp_wrong,
  input  logic              ari_ins_flag,
  input  logic [`ILEN-1:0]  ari_insty,
  input  logic [`RLEN-1:0]  ari_val1,
  input  logic [`RLEN-1:0]  ari_val2,
  input  logic [`RBID-1:0]  ari_ROB_idx,
  output logic              val_flag_RS,
  output logic [`RBID-1:0]  val_idx_RS,
  output logic [`RLEN-1:0]  val_RS,
  output logic [31:0]       exec_cnt
);

  logic             r_e1_valid;
  logic [`ILEN-1:0] r_e1_op;
  logic [`RLEN-1:0] r_e1_a;
  logic [`RLEN-1:0] r_e1_b;
  logic [`RBID-1:0] r_e1_idx;

  logic [`RLEN-1:0] w_result;
  logic [`RLEN-1:0] w_sum;
  logic [4:0]       w_shamt;
  logic             w_lt_s;
  logic             w_lt_u;
  logic             w_eq;

  assign w_sum   = r_e1_a + r_e1_b;
  assign w_shamt = r_e1_b[4:0];
  assign w_lt_s  = $signed(r_e1_a) < $signed(r_e1_b);
  assign w_lt_u  = r_e1_a < r_e1_b;
  assign w_eq    = r_e1_a == r_e1_b;

  always_comb begin
    w_result = '0;
    case (r_e1_op)
      c_ADD, c_ADDI:   w_result = w_sum;
      c_SUB:           w_result = r_e1_a - r_e1_b;
      c_AND, c_ANDI:   w_result = r_e1_a & r_e1_b;
      c_OR, c_ORI:     w_result = r_e1_a | r_e1_b;
      c_XOR, c_XORI:   w_result = r_e1_a ^ r_e1_b;
      c_SLL, c_SLLI:   w_result = r_e1_a << w_shamt;
      c_SRL, c_SRLI:   w_result = r_e1_a >> w_shamt;
      c_SRA, c_SRAI:   w_result = $unsigned($signed(r_e1_a) >>> w_shamt);
      c_SLT, c_SLTI:   w_result = {{(`RLEN-1){1'b0}}, w_lt_s};
      c_SLTU, c_SLTIU: w_result = {{(`RLEN-1){1'b0}}, w_lt_u};
      c_BEQ:           w_result = {{(`RLEN-1){1'b0}}, w_eq};
      c_BNE:           w_result = {{(`RLEN-1){1'b0}}, ~w_eq};
      c_BLT:           w_result = {{(`RLEN-1){1'b0}}, w_lt_s};
      c_BGE:           w_result = {{(`RLEN-1){1'b0}}, ~w_lt_s};
      c_BLTU:          w_result = {{(`RLEN-1){1'b0}}, w_lt_u};
      c_BGEU:          w_result = {{(`RLEN-1){1'b0}}, ~w_lt_u};
      c_JALR:          w_result = {w_sum[`RLEN-1:1], 1'b0};
      default:         w_result = '0;
    endcase
  end

  // Flush drops both the in-flight E1 entry and this cycle's issue; the
  // data/index registers are left stale since their valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_e1_valid  <= 1'b0;
      r_e1_op     <= '0;
      r_e1_a      <= '0;
      r_e1_b      <= '0;
      r_e1_idx    <= '0;
      val_flag_RS <= 1'b0;
      val_idx_RS  <= '0;
      val_RS      <= '0;
      exec_cnt    <= '0;
    end else if (rdy) begin
      if (jp_wrong) begin
        r_e1_valid  <= 1'b0;
        val_flag_RS <= 1'b0;
      end else begin
        r_e1_valid  <= ari_ins_flag;
        r_e1_op     <= ari_insty;
        r_e1_a      <= ari_val1;
        r_e1_b      <= ari_val2;
        r_e1_idx    <= ari_ROB_idx;
        val_flag_RS <= r_e1_valid;
        val_idx_RS  <= r_e1_idx;
        val_RS      <= w_result;
        if (r_e1_valid) begin
          exec_cnt <= exec_cnt + 32'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking bench for alu_pipe: vector table, directed corner
//            sequences and a randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ILEN
`define ILEN 6
`endif
`ifndef RLEN
`define RLEN 32
`endif
`ifndef RBID
`define RBID 4
`endif

module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              jp_wrong;
  logic              ari_ins_flag;
  logic [`ILEN-1:0]  ari_insty;
  logic [`RLEN-1:0]  ari_val1;
  logic [`RLEN-1:0]  ari_val2;
  logic [`RBID-1:0]  ari_ROB_idx;
  logic              val_flag_RS;
  logic [`RBID-1:0]  val_idx_RS;
  logic [`RLEN-1:0]  val_RS;
  logic [31:0]       exec_cnt;

  int n_checks = 0;
  int n_errors = 0;

  alu_pipe dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .ari_ins_flag(ari_ins_flag), .ari_insty(ari_insty),
    .ari_val1(ari_val1), .ari_val2(ari_val2), .ari_ROB_idx(ari_ROB_idx),
    .val_flag_RS(val_flag_RS), .val_idx_RS(val_idx_RS), .val_RS(val_RS),
    .exec_cnt(exec_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [`ILEN-1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [`RBID-1:0] idx);
    ari_ins_flag = 1'b1;
    ari_insty    = op;
    ari_val1     = a;
    ari_val2     = b;
    ari_ROB_idx  = idx;
  endtask

  task automatic idle();
    ari_ins_flag = 1'b0;
    ari_insty    = '0;
    ari_val1     = '0;
    ari_val2     = '0;
    ari_ROB_idx  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; jp_wrong = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Reference result computed directly from the ISA definitions.
  function automatic logic [31:0] ref_result(input logic [`ILEN-1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      c_ADD, c_ADDI:   return a + b;
      c_SUB:           return a - b;
      c_AND, c_ANDI:   return a & b;
      c_OR, c_ORI:     return a | b;
      c_XOR, c_XORI:   return a ^ b;
      c_SLL, c_SLLI:   return a << (b % 32);
      c_SRL, c_SRLI:   return a >> (b % 32);
      c_SRA, c_SRAI:   return sa >>> (b % 32);
      c_SLT, c_SLTI:   return (sa < sb) ? 32'd1 : 32'd0;
      c_SLTU, c_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      c_BEQ:           return (a == b) ? 32'd1 : 32'd0;
      c_BNE:           return (a != b) ? 32'd1 : 32'd0;
      c_BLT:           return (sa < sb) ? 32'd1 : 32'd0;
      c_BGE:           return (sa >= sb) ? 32'd1 : 32'd0;
      c_BLTU:          return (a < b) ? 32'd1 : 32'd0;
      c_BGEU:          return (a >= b) ? 32'd1 : 32'd0;
      c_JALR:          return (a + b) & 32'hFFFF_FFFE;
      default:         return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [`ILEN-1:0] op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      exp;
  } vec_t;

  typedef struct {
    logic [`RBID-1:0] idx;
    logic [31:0]      val;
  } res_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] m_cnt;
    res_t        pend[$];
    res_t        bus;
    logic        m_flag;
    res_t        r;

    vecs[0]  = '{c_SLT,   32'hFFFF_FFFF, 32'd1, 32'd1};
    vecs[1]  = '{c_SLTU,  32'hFFFF_FFFF, 32'd1, 32'd0};
    vecs[2]  = '{c_BGE,   32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd1};
    vecs[3]  = '{c_BLTU,  32'd2, 32'd1, 32'd0};
    vecs[4]  = '{c_JALR,  32'h0000_1001, 32'd4, 32'h0000_1004};
    vecs[5]  = '{c_SLL,   32'h0000_0001, 32'd31, 32'h8000_0000};
    vecs[6]  = '{c_SRL,   32'h8000_0000, 32'd31, 32'h0000_0001};
    vecs[7]  = '{c_BNE,   32'd5, 32'd5, 32'd0};
    vecs[8]  = '{c_BLT,   32'h8000_0000, 32'd0, 32'd1};
    vecs[9]  = '{c_BGEU,  32'h8000_0000, 32'd0, 32'd1};
    vecs[10] = '{c_ORI,   32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F};
    vecs[11] = '{6'd63,   32'h1234_5678, 32'h1, 32'd0};

    // Reset with issue asserted, then first issue two edges after release
    rst = 1'b0; rdy = 1'b1; jp_wrong = 1'b0;
    issue(c_ADD, 32'd1, 32'd2, 4'd9);
    tick();
    tick();
    chk("reset_flag", {31'd0, val_flag_RS}, 32'd0);
    chk("reset_cnt", exec_cnt, 32'd0);
    chk("reset_val", val_RS, 32'd0);
    rst = 1'b1;
    tick();
    idle();
    chk("first_issue_not_yet", {31'd0, val_flag_RS}, 32'd0);
    tick();
    chk("first_issue_flag", {31'd0, val_flag_RS}, 32'd1);
    chk("first_issue_idx", {28'd0, val_idx_RS}, 32'd9);
    chk("first_issue_val", val_RS, 32'd3);
    tick();
    chk("first_issue_one_cycle", {31'd0, val_flag_RS}, 32'd0);

    // Back-to-back arithmetic
    do_reset();
    issue(c_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3); tick();
    issue(c_SUB, 32'd0, 32'd1, 4'd4);         tick();
    chk("b2b0_flag", {31'd0, val_flag_RS}, 32'd1);
    chk("b2b0_idx", {28'd0, val_idx_RS}, 32'd3);
    chk("b2b0_val", val_RS, 32'd0);
    issue(c_SRA, 32'h8000_0000, 32'h21, 4'd5); tick();
    chk("b2b1_flag", {31'd0, val_flag_RS}, 32'd1);
    chk("b2b1_idx", {28'd0, val_idx_RS}, 32'd4);
    chk("b2b1_val", val_RS, 32'hFFFF_FFFF);
    idle(); tick();
    chk("b2b2_flag", {31'd0, val_flag_RS}, 32'd1);
    chk("b2b2_idx", {28'd0, val_idx_RS}, 32'd5);
    chk("b2b2_val", val_RS, 32'hC000_0000);
    tick();
    chk("b2b_cnt", exec_cnt, 32'd3);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d_flag", i), {31'd0, val_flag_RS}, 32'd1);
      chk($sformatf("vec%0d_idx", i), {28'd0, val_idx_RS}, 32'(i));
      chk($sformatf("vec%0d_val", i), val_RS, vecs[i].exp);
    end

    // Flush: A at N, B at N+1 with jp_wrong, C at N+2
    do_reset();
    issue(c_ADD, 32'd10, 32'd20, 4'd1); tick();
    issue(c_ADD, 32'd30, 32'd40, 4'd2); jp_wrong = 1'b1; tick();
    chk("flush_A_dropped", {31'd0, val_flag_RS}, 32'd0);
    jp_wrong = 1'b0;
    issue(c_OR, 32'h5, 32'hA, 4'd6); tick();
    chk("flush_B_dropped", {31'd0, val_flag_RS}, 32'd0);
    idle(); tick();
    chk("flush_C_flag", {31'd0, val_flag_RS}, 32'd1);
    chk("flush_C_idx", {28'd0, val_idx_RS}, 32'd6);
    chk("flush_C_val", val_RS, 32'hF);
    chk("flush_cnt", exec_cnt, 32'd1);

    // Stall with result on the bus
    do_reset();
    issue(c_XOR, 32'hF0F0, 32'h0FF0, 4'd7); tick();
    idle(); tick();
    rdy = 1'b0; jp_wrong = 1'b1;
    issue(c_ADD, 32'd1, 32'd1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_flag", i), {31'd0, val_flag_RS}, 32'd1);
      chk($sformatf("stall%0d_idx", i), {28'd0, val_idx_RS}, 32'd7);
      chk($sformatf("stall%0d_val", i), val_RS, 32'h0000_FF00);
      chk($sformatf("stall%0d_cnt", i), exec_cnt, 32'd1);
    end
    rdy = 1'b1; jp_wrong = 1'b0;
    idle(); tick();
    chk("stall_release_flag", {31'd0, val_flag_RS}, 32'd0);
    tick();
    chk("stall_ignored_issue", {31'd0, val_flag_RS}, 32'd0);
    chk("stall_release_cnt", exec_cnt, 32'd1);

    // Counter wrap via backdoor load
    do_reset();
    tick();
    force dut.exec_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.exec_cnt;
    chk("wrap_preload", exec_cnt, 32'hFFFF_FFFF);
    issue(c_ADD, 32'd0, 32'd0, 4'd1); tick();
    idle(); tick();
    chk("wrap_flag", {31'd0, val_flag_RS}, 32'd1);
    chk("wrap_cnt", exec_cnt, 32'd0);

    // Randomized run against the reference model
    do_reset();
    tick();
    m_cnt = 0; m_flag = 1'b0; bus = '{'0, '0}; pend.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      jp_wrong = ($urandom_range(0, 11) == 0);
      ari_ins_flag = ($urandom_range(0, 3) != 0);
      ari_insty    = `ILEN'($urandom_range(0, 28));
      ari_val1     = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      ari_val2     = ($urandom_range(0, 3) == 0) ? ari_val1 : $urandom;
      ari_ROB_idx  = `RBID'($urandom);
      @(posedge clk);
      if (rdy) begin
        if (jp_wrong) begin
          pend.delete();
          m_flag = 1'b0;
        end else begin
          m_flag = (pend.size() != 0);
          if (m_flag) begin
            bus = pend.pop_front();
            m_cnt++;
          end
          if (ari_ins_flag) begin
            r.idx = ari_ROB_idx;
            r.val = ref_result(ari_insty, ari_val1, ari_val2);
            pend.push_back(r);
          end
        end
      end
      #1;
      chk($sformatf("rnd%0d_flag", cyc), {31'd0, val_flag_RS}, {31'd0, m_flag});
      if (m_flag) begin
        chk($sformatf("rnd%0d_idx", cyc), {28'd0, val_idx_RS}, {28'd0, bus.idx});
        chk($sformatf("rnd%0d_val", cyc), val_RS, bus.val);
      end
      chk($sformatf("rnd%0d_cnt", cyc), exec_cnt, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
